// File: rtl/execution_pkg.sv
// Shared definitions for the execute stage: ALU op codes, mul/div FSM states
// and default field widths. The mul/div unit is built only when the macro
// EXECUTION_MULDIV_EN is defined.
package execution_pkg;

  localparam int NB_ALUOP_DFLT = 5;
  localparam int NB_SHAMT_DFLT = 5;

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_AND   = 5'd2;
  localparam logic [4:0] OP_OR    = 5'd3;
  localparam logic [4:0] OP_XOR   = 5'd4;
  localparam logic [4:0] OP_NOR   = 5'd5;
  localparam logic [4:0] OP_SLT   = 5'd6;
  localparam logic [4:0] OP_SLTU  = 5'd7;
  localparam logic [4:0] OP_SLL   = 5'd8;
  localparam logic [4:0] OP_SRL   = 5'd9;
  localparam logic [4:0] OP_SRA   = 5'd10;
  localparam logic [4:0] OP_LUI   = 5'd11;
  localparam logic [4:0] OP_MULT  = 5'd12;
  localparam logic [4:0] OP_MULTU = 5'd13;
  localparam logic [4:0] OP_DIV   = 5'd14;
  localparam logic [4:0] OP_DIVU  = 5'd15;
  localparam logic [4:0] OP_MFHI  = 5'd16;
  localparam logic [4:0] OP_MFLO  = 5'd17;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } md_state_t;

endpackage

// File: rtl/execution_muldiv_unit.sv
// Iterative multiply/divide unit: one shift-add or restoring-divide step per
// enabled cycle, 32 steps per operation, results committed to HI/LO at the end.
// Signed operations run on magnitudes and fix the sign in the final step.
module muldiv_unit
  import execution_pkg::*;
#(
  parameter int NB_REG   = 32,
  parameter int NB_ALUOP = NB_ALUOP_DFLT
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_valid,
  input  logic                i_start,
  input  logic [NB_ALUOP-1:0] i_op,
  input  logic [NB_REG-1:0]   i_a,
  input  logic [NB_REG-1:0]   i_b,
  output logic [NB_REG-1:0]   o_hi,
  output logic [NB_REG-1:0]   o_lo,
  output logic                o_busy
);

  localparam int NB_CNT = $clog2(NB_REG);
  localparam logic [NB_CNT-1:0] CNT_LAST = NB_CNT'(NB_REG - 1);

  md_state_t           state;
  logic [NB_CNT-1:0]   cnt;
  logic [NB_REG-1:0]   acc_hi;   // partial product high half / remainder
  logic [NB_REG-1:0]   acc_lo;   // multiplier / dividend shifting into quotient
  logic [NB_REG-1:0]   opnd;     // multiplicand or divisor magnitude
  logic                is_div;
  logic                neg_res;  // product / quotient must be negated
  logic                neg_rem;  // remainder takes dividend sign
  logic                div_zero;
  logic [NB_REG-1:0]   hi_r;
  logic [NB_REG-1:0]   lo_r;

  logic                is_signed_s;
  logic                sign_a_s;
  logic                sign_b_s;
  logic [NB_REG-1:0]   mag_a_s;
  logic [NB_REG-1:0]   mag_b_s;
  logic [NB_REG:0]     mul_sum_s;
  logic [NB_REG:0]     trial_s;
  logic [NB_REG-1:0]   step_hi_s;
  logic [NB_REG-1:0]   step_lo_s;
  logic [2*NB_REG-1:0] prod_s;
  logic [NB_REG-1:0]   fin_hi_s;
  logic [NB_REG-1:0]   fin_lo_s;

  assign o_busy = (state == ST_BUSY);
  assign o_hi   = hi_r;
  assign o_lo   = lo_r;

  // Operand sign extraction and magnitude conversion at acceptance.
  always_comb begin
    is_signed_s = (i_op == OP_MULT) || (i_op == OP_DIV);
    sign_a_s    = is_signed_s & i_a[NB_REG-1];
    sign_b_s    = is_signed_s & i_b[NB_REG-1];
    mag_a_s     = sign_a_s ? (~i_a + {{(NB_REG-1){1'b0}}, 1'b1}) : i_a;
    mag_b_s     = sign_b_s ? (~i_b + {{(NB_REG-1){1'b0}}, 1'b1}) : i_b;
  end

  // One datapath step plus the sign-corrected final result.
  always_comb begin
    mul_sum_s = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : {(NB_REG+1){1'b0}});
    trial_s   = {acc_hi, acc_lo[NB_REG-1]} - {1'b0, opnd};
    if (is_div) begin
      if (!trial_s[NB_REG]) begin
        step_hi_s = trial_s[NB_REG-1:0];
        step_lo_s = {acc_lo[NB_REG-2:0], 1'b1};
      end else begin
        step_hi_s = {acc_hi[NB_REG-2:0], acc_lo[NB_REG-1]};
        step_lo_s = {acc_lo[NB_REG-2:0], 1'b0};
      end
    end else begin
      step_hi_s = mul_sum_s[NB_REG:1];
      step_lo_s = {mul_sum_s[0], acc_lo[NB_REG-1:1]};
    end
    prod_s = {step_hi_s, step_lo_s};
    if (is_div) begin
      fin_hi_s = neg_rem ? (~step_hi_s + {{(NB_REG-1){1'b0}}, 1'b1}) : step_hi_s;
      if (div_zero) begin
        fin_lo_s = {NB_REG{1'b1}};
      end else begin
        fin_lo_s = neg_res ? (~step_lo_s + {{(NB_REG-1){1'b0}}, 1'b1}) : step_lo_s;
      end
    end else begin
      if (neg_res) begin
        prod_s = ~prod_s + {{(2*NB_REG-1){1'b0}}, 1'b1};
      end else begin
        prod_s = prod_s;
      end
      fin_hi_s = prod_s[2*NB_REG-1:NB_REG];
      fin_lo_s = prod_s[NB_REG-1:0];
    end
  end

  // FSM, iteration counter, working registers and HI/LO commit.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state    <= ST_IDLE;
      cnt      <= {NB_CNT{1'b0}};
      acc_hi   <= {NB_REG{1'b0}};
      acc_lo   <= {NB_REG{1'b0}};
      opnd     <= {NB_REG{1'b0}};
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi_r     <= {NB_REG{1'b0}};
      lo_r     <= {NB_REG{1'b0}};
    end else if (i_valid) begin
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state    <= ST_BUSY;
            cnt      <= {NB_CNT{1'b0}};
            acc_hi   <= {NB_REG{1'b0}};
            is_div   <= (i_op == OP_DIV) || (i_op == OP_DIVU);
            neg_res  <= sign_a_s ^ sign_b_s;
            neg_rem  <= sign_a_s;
            div_zero <= (i_b == {NB_REG{1'b0}});
            if ((i_op == OP_DIV) || (i_op == OP_DIVU)) begin
              acc_lo <= mag_a_s;
              opnd   <= mag_b_s;
            end else begin
              acc_lo <= mag_b_s;
              opnd   <= mag_a_s;
            end
          end
        end
        ST_BUSY: begin
          acc_hi <= step_hi_s;
          acc_lo <= step_lo_s;
          cnt    <= cnt + {{(NB_CNT-1){1'b0}}, 1'b1};
          if (cnt == CNT_LAST) begin
            state <= ST_IDLE;
            hi_r  <= fin_hi_s;
            lo_r  <= fin_lo_s;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/execution.sv
// Execute stage of the 5-stage MIPS pipeline: single-cycle ALU and the
// EX/MEM pipeline register. Define EXECUTION_MULDIV_EN to build the iterative
// MULT/MULTU/DIV/DIVU unit with HI/LO; without it ops 12..17 yield 0.
module execution
  import execution_pkg::*;
#(
  parameter int NB_REG   = 32,
  parameter int NB_MEM   = 5,
  parameter int NB_WB    = 8,
  parameter int NB_ALUOP = NB_ALUOP_DFLT,
  parameter int NB_SHAMT = NB_SHAMT_DFLT
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_valid,
  input  logic [NB_REG-1:0]   i_a,
  input  logic [NB_REG-1:0]   i_b,
  input  logic [NB_REG-1:0]   i_imm,
  input  logic                i_alu_src,
  input  logic [NB_SHAMT-1:0] i_shamt,
  input  logic [NB_ALUOP-1:0] i_alu_op,
  input  logic [NB_MEM-1:0]   i_mem,
  input  logic [NB_WB-1:0]    i_wb,
  input  logic [NB_REG-1:0]   i_pc,
  output logic [NB_REG-1:0]   o_alu_o,
  output logic [NB_REG-1:0]   o_b_o,
  output logic [NB_MEM-1:0]   o_mem,
  output logic [NB_WB-1:0]    o_wb,
  output logic [NB_REG-1:0]   o_pc,
  output logic                o_stall
);

  logic [NB_REG-1:0] op_b_s;
  logic [NB_REG-1:0] alu_s;
  logic              bubble_s;
  logic              busy_s;
  logic              start_s;
  logic [NB_REG-1:0] hi_s;
  logic [NB_REG-1:0] lo_s;

  assign op_b_s = i_alu_src ? i_imm : i_b;

`ifdef EXECUTION_MULDIV_EN
  assign start_s = ~busy_s && ((i_alu_op == OP_MULT) || (i_alu_op == OP_MULTU) ||
                               (i_alu_op == OP_DIV)  || (i_alu_op == OP_DIVU));

  muldiv_unit #(
    .NB_REG   (NB_REG),
    .NB_ALUOP (NB_ALUOP)
  ) u_muldiv (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_valid (i_valid),
    .i_start (start_s),
    .i_op    (i_alu_op),
    .i_a     (i_a),
    .i_b     (op_b_s),
    .o_hi    (hi_s),
    .o_lo    (lo_s),
    .o_busy  (busy_s)
  );
`else
  assign start_s = 1'b0;
  assign busy_s  = 1'b0;
  assign hi_s    = {NB_REG{1'b0}};
  assign lo_s    = {NB_REG{1'b0}};
`endif

  assign o_stall  = busy_s;
  assign bubble_s = busy_s | start_s;

  // Single-cycle ALU result selection.
  always_comb begin
    alu_s = {NB_REG{1'b0}};
    case (i_alu_op)
      OP_ADD:  alu_s = i_a + op_b_s;
      OP_SUB:  alu_s = i_a - op_b_s;
      OP_AND:  alu_s = i_a & op_b_s;
      OP_OR:   alu_s = i_a | op_b_s;
      OP_XOR:  alu_s = i_a ^ op_b_s;
      OP_NOR:  alu_s = ~(i_a | op_b_s);
      OP_SLT:  alu_s = {{(NB_REG-1){1'b0}}, ($signed(i_a) < $signed(op_b_s))};
      OP_SLTU: alu_s = {{(NB_REG-1){1'b0}}, (i_a < op_b_s)};
      OP_SLL:  alu_s = op_b_s << i_shamt;
      OP_SRL:  alu_s = op_b_s >> i_shamt;
      OP_SRA:  alu_s = $unsigned($signed(op_b_s) >>> i_shamt);
      OP_LUI:  alu_s = {op_b_s[15:0], 16'h0000};
      OP_MFHI: alu_s = hi_s;
      OP_MFLO: alu_s = lo_s;
      default: alu_s = {NB_REG{1'b0}};
    endcase
  end

  // EX/MEM pipeline register; mul/div cycles load a bubble.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_alu_o <= {NB_REG{1'b0}};
      o_b_o   <= {NB_REG{1'b0}};
      o_mem   <= {NB_MEM{1'b0}};
      o_wb    <= {NB_WB{1'b0}};
      o_pc    <= {NB_REG{1'b0}};
    end else if (i_valid) begin
      o_b_o <= i_b;
      o_pc  <= i_pc;
      if (bubble_s) begin
        o_alu_o <= {NB_REG{1'b0}};
        o_mem   <= {NB_MEM{1'b0}};
        o_wb    <= {NB_WB{1'b0}};
      end else begin
        o_alu_o <= alu_s;
        o_mem   <= i_mem;
        o_wb    <= i_wb;
      end
    end
  end

endmodule

// File: doc/execution.md
Name: execution

Overview:
- Execute stage of the 5-stage MIPS pipeline, sitting between decode and memory_access.
- Performs single-cycle ALU operations and iterative 32-step MULT/MULTU/DIV/DIVU into HI/LO registers.
- Registers its results into the EX/MEM pipeline register that feeds memory_access: alu_o, b_o, mem, wb, pc.
- Asserts o_stall toward upstream stages while a multiply/divide is in progress.

Parameters:
- NB_REG, 32, datapath width.
- NB_MEM, 5, memory control bundle width {re,we,s_u,dsize[1:0]}, passed through.
- NB_WB, 8, write-back control bundle width, passed through.
- NB_ALUOP, 5, ALU operation code width.
- NB_SHAMT, 5, shift amount width.

Ports:
- i_clock  in  1  single clock; all state updates on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  global pipeline advance enable.
- i_a  in  NB_REG  rs operand.
- i_b  in  NB_REG  rt operand; also store data.
- i_imm  in  NB_REG  immediate, already extended by decode.
- i_alu_src  in  1  1: second operand = i_imm; 0: second operand = i_b.
- i_shamt  in  NB_SHAMT  shift amount.
- i_alu_op  in  NB_ALUOP  operation code.
- i_mem  in  NB_MEM  memory control bundle.
- i_wb  in  NB_WB  write-back control bundle.
- i_pc  in  NB_REG  pc of the instruction.
- o_alu_o  out  NB_REG  registered result; used as the memory address for loads/stores.
- o_b_o  out  NB_REG  registered i_b.
- o_mem  out  NB_MEM  registered i_mem.
- o_wb  out  NB_WB  registered i_wb.
- o_pc  out  NB_REG  registered i_pc.
- o_stall  out  1  multiply/divide busy; upstream holds its inputs while high.

Behaviour:
- Op codes:
  - ADD 0, SUB 1, AND 2, OR 3, XOR 4, NOR 5, SLT 6, SLTU 7.
  - SLL 8, SRL 9, SRA 10, LUI 11.
  - MULT 12, MULTU 13, DIV 14, DIVU 15, MFHI 16, MFLO 17.
  - Any other code: result 0.
- Arithmetic rules:
  - ADD/SUB wrap modulo 2^NB_REG; no overflow trap.
  - SLT is signed and SLTU unsigned; both produce 0 or 1.
  - Shifts apply i_shamt to the second operand.
  - LUI = {opB[15:0], 16'h0}.
- Reset: on i_reset all outputs, HI, LO and the iteration counter go to 0; state goes to IDLE.
  - Reset during BUSY aborts the operation; HI/LO become 0.
- Normal operation (i_valid=1, o_stall=0): outputs load the new instruction; latency is 1 cycle.
- i_valid=0: all registers hold, including FSM state, counter and HI/LO.
- FSM IDLE to BUSY: in IDLE with i_valid=1 and op in {12..15}:
  - capture operands;
  - counter = 0, state goes to BUSY;
  - the instruction enters the output register as a bubble (o_mem=0, o_wb=0, o_alu_o=0).
- FSM BUSY:
  - o_stall = (state==BUSY), combinational from state;
  - one multiply step (shift-add) or restoring-divide step per i_valid cycle;
  - output register loads a bubble each cycle (o_mem=0, o_wb=0);
  - when counter reaches NB_REG-1: write HI/LO and return to IDLE.
  - o_stall is therefore high for exactly NB_REG valid cycles after acceptance.
- Results:
  - MULT/MULTU: {HI,LO} = full 64-bit product.
  - DIV/DIVU: LO = quotient, HI = remainder; the remainder takes the dividend's sign.
  - Signed ops use operand magnitudes, with sign correction in the last step.
- Boundary cases:
  - Divide by zero: LO = all ones, HI = dividend, for both signed and unsigned.
  - DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- MFHI/MFLO: result = HI/LO. They are never seen while BUSY, because upstream is stalled.
  - An MFHI issued in the cycle after o_stall falls reads the new HI.

Optional Feature:
- Macro: EXECUTION_MULDIV_EN.
- Defined: multiply/divide unit, HI/LO and FSM as above.
- Undefined:
  - ops 12..17 produce result 0 with normal single-cycle pass-through of i_mem/i_wb;
  - o_stall is tied to 0;
  - no HI/LO registers are inferred.

Decomposition:
- Package execution_pkg: ALU op code localparams, FSM state encodings (IDLE, BUSY), and the NB_ALUOP/NB_SHAMT defaults.
- Sub-module muldiv_unit: operands, op, start in; HI, LO, busy out.
  - It contains the FSM, counter and shift/subtract datapath.
  - It is instantiated only under EXECUTION_MULDIV_EN.

Test Plan:
- ADD 0x7FFFFFFF + 1, i_alu_src=0 -> o_alu_o=0x80000000 one cycle later; o_mem/o_wb/o_pc equal to inputs.
- SRA i_b=0x80000000, shamt=4 -> 0xF8000000. SLT -1 vs 1 -> 1. SLTU -1 vs 1 -> 0.
- MULT 0xFFFFFFFE(-2) x 3:
  - o_stall high 32 cycles; output bubbles (o_wb=0);
  - then MFHI -> 0xFFFFFFFF and MFLO -> 0xFFFFFFFA.
- DIVU 7/0 -> LO=0xFFFFFFFF, HI=7.
- DIV -7/2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV 0x80000000/-1 -> LO=0x80000000, HI=0.
- Start MULT, assert i_reset at BUSY cycle 10 -> next cycle o_stall=0, HI=LO=0, all outputs 0.
- Hold i_valid=0 for 5 cycles mid-DIV -> stall lengthens by 5 cycles; result unchanged.
